// File: rtl/tanh_arb_sched.sv
// Round-robin scheduler sharing one combinational tanh unit among N_REQ requesters.
// Optional macro TANH_SCHED_SAT_BYPASS_EN: saturated inputs skip the unit and finish one cycle early.
module tanh_arb_sched #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int ID_W   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_z,
    output logic [N_REQ-1:0]           req_ready,
    output logic signed [DATA_W-1:0]   act_z,
    input  logic signed [DATA_W-1:0]   act_a,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic signed [DATA_W-1:0]   res_a,
    output logic [ID_W-1:0]            res_id,
    output logic                       busy
);

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t                   state_q, state_d;
    logic [ID_W-1:0]          ptr_q, ptr_d;
    logic [ID_W-1:0]          id_q, id_d;
    logic signed [DATA_W-1:0] actz_q, actz_d;
    logic signed [DATA_W-1:0] resa_q, resa_d;
    logic [N_REQ-1:0]         ready_c;

    logic                     grant;
    logic [ID_W-1:0]          win;
    logic signed [DATA_W-1:0] win_z;

`ifdef TANH_SCHED_SAT_BYPASS_EN
    // Q8.24: 1.0 and the |z| >= 8.0 saturation threshold
    localparam logic signed [DATA_W-1:0] ONE_C = DATA_W'(1 << 24);
    localparam logic signed [DATA_W-1:0] SAT_C = DATA_W'(8 << 24);

    function automatic logic sat_hit(input logic signed [DATA_W-1:0] z);
        return (z >= SAT_C) || (z < -SAT_C);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_val(input logic signed [DATA_W-1:0] z);
        return (z >= SAT_C) ? ONE_C : -ONE_C;
    endfunction
`endif

    // First valid requester at or after ptr, wrapping at N_REQ.
    always_comb begin
        int              idx_i;
        logic [ID_W-1:0] idx_w;
        grant = 1'b0;
        win   = '0;
        win_z = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_i = int'(ptr_q) + k;
            if (idx_i >= N_REQ) idx_i = idx_i - N_REQ;
            idx_w = ID_W'(idx_i);
            if (!grant && req_valid[idx_w]) begin
                grant = 1'b1;
                win   = idx_w;
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (ID_W'(k) == win) win_z = req_z[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        actz_d  = actz_q;
        resa_d  = resa_q;
        ready_c = '0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    ready_c[win] = 1'b1;
                    ptr_d        = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
                    id_d         = win;
`ifdef TANH_SCHED_SAT_BYPASS_EN
                    if (sat_hit(win_z)) begin
                        resa_d  = sat_val(win_z);
                        state_d = DONE;
                    end else begin
                        actz_d  = win_z;
                        state_d = EVAL;
                    end
`else
                    actz_d  = win_z;
                    state_d = EVAL;
`endif
                end
            end
            EVAL: begin
                resa_d  = act_a;
                state_d = DONE;
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            actz_q  <= '0;
            resa_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            actz_q  <= actz_d;
            resa_q  <= resa_d;
        end
    end

    // The grant strobe is combinational, so it is masked while reset is held.
    assign req_ready = rst_n ? ready_c : '0;
    assign act_z     = actz_q;
    assign res_a     = resa_q;
    assign res_id    = id_q;
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/tanh_arb_sched.md
TANH_ARB_SCHED -- requirements
Module: tanh_arb_sched

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters sharing one tanh unit.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the signed Q8.24 value width, where 1.0 = 0x01000000.
REQ-003 The block SHALL have parameter ID_W, default 2, meaning the requester index width (clog2 N_REQ).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port req_valid, input, N_REQ bits: per-requester request valid.
REQ-007 The block SHALL have port req_z, input, N_REQ*DATA_W bits: per-requester z value; slice i is bits [i*DATA_W +: DATA_W].
REQ-008 The block SHALL have port req_ready, output, N_REQ bits: per-requester accept strobe, one-hot or zero.
REQ-009 The block SHALL have port act_z, output, DATA_W bits: z driven to the shared combinational tanh unit.
REQ-010 The block SHALL have port act_a, input, DATA_W bits: tanh result returned from the shared unit, valid in the same cycle.
REQ-011 The block SHALL have port res_valid, output, 1 bit: result valid.
REQ-012 The block SHALL have port res_ready, input, 1 bit: result consumer ready.
REQ-013 The block SHALL have port res_a, output, DATA_W bits: result value.
REQ-014 The block SHALL have port res_id, output, ID_W bits: index of the requester the result belongs to.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, EVAL and DONE.
REQ-017 In IDLE with any req_valid bit high, the block SHALL grant the round-robin winner: req_ready[w] high for exactly that cycle, z and id latched, and a move to EVAL.
REQ-018 Round-robin SHALL search from index ptr upward, wrapping at N_REQ; on each grant, ptr becomes (w+1) mod N_REQ.
REQ-019 In IDLE with req_valid all zero, the block SHALL hold req_ready at zero and ptr unchanged.
REQ-020 In EVAL, act_z SHALL equal the latched z; act_a SHALL be registered into res_a, and the FSM SHALL move to DONE after one cycle.
REQ-021 Outside EVAL, act_z SHALL hold its last value, with no glitch requirement.
REQ-022 In DONE, res_valid SHALL be 1, and res_a and res_id SHALL be stable until res_valid && res_ready, then the FSM returns to IDLE.
REQ-023 The block SHALL accept no new request while in EVAL or DONE; req_ready SHALL be 0 there.
REQ-024 Latency SHALL be: grant at cycle G, res_valid at G+2; peak throughput is one result per 3 cycles.
REQ-025 A requester dropping req_valid without a grant SHALL lose nothing; the block never latches ungranted data.
REQ-026 A request at ptr and a higher index arriving simultaneously SHALL resolve to ptr.

Reset
REQ-027 On rst_n low, the block SHALL asynchronously set state=IDLE, ptr=0, res_valid=0, res_a=0, res_id=0, act_z=0, busy=0 and req_ready=0.
REQ-028 Reset asserted in EVAL or DONE SHALL discard the pending result, with no res_valid after release.
REQ-029 On the first rising edge after rst_n rises, the block SHALL arbitrate normally.

Configuration
REQ-030 With macro TANH_SCHED_SAT_BYPASS_EN defined, a granted z >= 0x08000000 SHALL yield res_a=0x01000000, and z < 0xF8000000 (signed) SHALL yield res_a=0xFF000000; IDLE goes straight to DONE with latency G+1 and act_z unchanged.
REQ-031 Without TANH_SCHED_SAT_BYPASS_EN, every request SHALL go through EVAL regardless of value.

Verification
REQ-032 Reset, then req_valid=0001, z0=0x00800000, unit model returns 0x0076A000 -> req_ready=0001 at G, res_valid at G+2, res_a=0x0076A000, res_id=0.
REQ-033 req_valid=1111 held, res_ready=1 -> grant order 0,1,2,3,0 and res_id sequence 0,1,2,3,0, one result every 3 cycles.
REQ-034 Result pending with res_ready=0 for 5 cycles while req_valid=0010 -> res_a and res_id stable, req_ready=0; grant to 1 on the cycle after res_ready goes high.
REQ-035 rst_n pulsed low during EVAL -> res_valid never rises, ptr=0, and the next grant goes to the lowest valid index.
REQ-036 TANH_SCHED_SAT_BYPASS_EN defined, z=0x09000000 then z=0xF0000000 -> res_a=0x01000000 then 0xFF000000, each at G+1, act_z untouched.
